// File: rtl/uop_sequencer_pkg.sv
// Shared micro-op definitions for the curve microcode sequencer: field layout,
// opcode / source / destination / exec encodings and the sequencer state type.
package uop_sequencer_pkg;

    localparam int UOP_ADDR_W   = 6;
    localparam int UOP_DATA_W   = 20;
    localparam int UOP_OPCODE_W = 4;
    localparam int UOP_SRC_W    = 5;
    localparam int UOP_DST_W    = 4;
    localparam int UOP_EXEC_W   = 2;

    // Last program word; advancing past it is a runaway program.
    localparam logic [UOP_ADDR_W-1:0] UOP_ADDR_LAST = '1;

    // Word layout, MSB first: [19:16] opcode, [15:11] src_a, [10:6] src_b,
    // [5:2] dst, [1:0] exec.
    typedef struct packed {
        logic [UOP_OPCODE_W-1:0] opcode;
        logic [UOP_SRC_W-1:0]    src_a;
        logic [UOP_SRC_W-1:0]    src_b;
        logic [UOP_DST_W-1:0]    dst;
        logic [UOP_EXEC_W-1:0]   exec;
    } uop_word_t;

    // Opcodes. OPCODE_RDY terminates the program.
    localparam logic [UOP_OPCODE_W-1:0] OPCODE_NOP = 4'h0;
    localparam logic [UOP_OPCODE_W-1:0] OPCODE_MOV = 4'h1;
    localparam logic [UOP_OPCODE_W-1:0] OPCODE_ADD = 4'h2;
    localparam logic [UOP_OPCODE_W-1:0] OPCODE_SUB = 4'h3;
    localparam logic [UOP_OPCODE_W-1:0] OPCODE_MUL = 4'h4;
    localparam logic [UOP_OPCODE_W-1:0] OPCODE_INV = 4'h5;
    localparam logic [UOP_OPCODE_W-1:0] OPCODE_RDY = 4'hF;

    // Operand source selects.
    localparam logic [UOP_SRC_W-1:0] UOP_SRC_G_X = 5'd1;
    localparam logic [UOP_SRC_W-1:0] UOP_SRC_G_Y = 5'd2;
    localparam logic [UOP_SRC_W-1:0] UOP_SRC_ONE = 5'd3;

    // Destination selects.
    localparam logic [UOP_DST_W-1:0] UOP_DST_RX = 4'd1;
    localparam logic [UOP_DST_W-1:0] UOP_DST_RY = 4'd2;
    localparam logic [UOP_DST_W-1:0] UOP_DST_RZ = 4'd3;

    // Exec condition codes.
    localparam logic [UOP_EXEC_W-1:0] UOP_EXEC_ALWAYS     = 2'b00;
    localparam logic [UOP_EXEC_W-1:0] UOP_EXEC_IF_BIT_SET = 2'b01;
    localparam logic [UOP_EXEC_W-1:0] UOP_EXEC_IF_BIT_CLR = 2'b10;
    localparam logic [UOP_EXEC_W-1:0] UOP_EXEC_NEVER      = 2'b11;

    // Sequencer states, exported so the state can be observed externally.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4
    } uop_state_e;

endpackage

// File: rtl/uop_sequencer_if.sv
// Bundle of the sequencer's control, ROM and datapath signals.
// Handshakes: ena is a start pulse accepted only while rdy=1 (idle); the ROM
// returns uop_data one clock after uop_addr changes; op_trig is a one-cycle
// issue pulse, op_* stay valid from op_trig until the datapath answers with
// op_done (sampled only while the sequencer waits for it).
interface uop_sequencer_if;
    import uop_sequencer_pkg::*;

    logic                    ena;
    logic                    rdy;
    logic                    err;
    logic                    cond_bit;
    logic [UOP_ADDR_W-1:0]   uop_addr;
    logic [UOP_DATA_W-1:0]   uop_data;
    logic                    op_trig;
    logic [UOP_OPCODE_W-1:0] op_code;
    logic [UOP_SRC_W-1:0]    op_src_a;
    logic [UOP_SRC_W-1:0]    op_src_b;
    logic [UOP_DST_W-1:0]    op_dst;
    logic                    op_done;

    // Sequencer side.
    modport master (
        input  ena, cond_bit, uop_data, op_done,
        output rdy, err, uop_addr, op_trig, op_code, op_src_a, op_src_b, op_dst
    );

    // Environment side: top-level FSM, ROM and datapath.
    modport slave (
        output ena, cond_bit, uop_data, op_done,
        input  rdy, err, uop_addr, op_trig, op_code, op_src_a, op_src_b, op_dst
    );

endinterface

// File: rtl/uop_sequencer.sv
// Microcode sequencer: walks the ROM from address 0, decodes each micro-op,
// gates it on its exec condition, issues it to the datapath and waits for
// completion. Stops at OPCODE_RDY, or flags err when the program runs off
// the end of the 64-word space.
module uop_sequencer
    import uop_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    uop_sequencer_if.master bus,
    output uop_state_e      state_o
);

    uop_state_e              state_q;
    logic                    rdy_q;
    logic                    err_q;
    logic [UOP_ADDR_W-1:0]   addr_q;
    logic                    trig_q;
    logic [UOP_OPCODE_W-1:0] code_q;
    logic [UOP_SRC_W-1:0]    src_a_q;
    logic [UOP_SRC_W-1:0]    src_b_q;
    logic [UOP_DST_W-1:0]    dst_q;

    uop_word_t uop_w;
    logic      is_rdy;
    logic      exec_ok;
    logic      advance;
    logic      at_last;

    // Decode the ROM word and evaluate its exec condition against cond_bit.
    always_comb begin
        uop_w   = uop_word_t'(bus.uop_data);
        is_rdy  = (uop_w.opcode == OPCODE_RDY);
        exec_ok = 1'b0;
        case (uop_w.exec)
            UOP_EXEC_ALWAYS:     exec_ok = 1'b1;
            UOP_EXEC_IF_BIT_SET: exec_ok = bus.cond_bit;
            UOP_EXEC_IF_BIT_CLR: exec_ok = ~bus.cond_bit;
            default:             exec_ok = 1'b0;
        endcase
        // Move to the next word: a skipped word in DECODE or a completed op in WAIT.
        advance = ((state_q == ST_DECODE) && !is_rdy && !exec_ok) ||
                  ((state_q == ST_WAIT) && bus.op_done);
        at_last = (addr_q == UOP_ADDR_LAST);
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
            err_q   <= 1'b0;
            addr_q  <= '0;
            trig_q  <= 1'b0;
            code_q  <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
        end else begin
            trig_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    addr_q <= '0;
                    if (bus.ena) begin
                        state_q <= ST_FETCH;
                        rdy_q   <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                // ROM read latency: the word for addr_q appears next cycle.
                ST_FETCH: state_q <= ST_DECODE;
                ST_DECODE: begin
                    if (is_rdy) begin
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b1;
                        addr_q  <= '0;
                    end else if (exec_ok) begin
                        state_q <= ST_ISSUE;
                        trig_q  <= 1'b1;
                        code_q  <= uop_w.opcode;
                        src_a_q <= uop_w.src_a;
                        src_b_q <= uop_w.src_b;
                        dst_q   <= uop_w.dst;
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT:  ;
                default:  state_q <= ST_IDLE;
            endcase

            if (advance) begin
                if (at_last) begin
                    // Runaway program: no RDY before the end of the ROM.
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b1;
                    err_q   <= 1'b1;
                    addr_q  <= '0;
                end else begin
                    state_q <= ST_FETCH;
                    addr_q  <= addr_q + 1'b1;
                end
            end
        end
    end

    assign bus.rdy      = rdy_q;
    assign bus.err      = err_q;
    assign bus.uop_addr = addr_q;
    assign bus.op_trig  = trig_q;
    assign bus.op_code  = code_q;
    assign bus.op_src_a = src_a_q;
    assign bus.op_src_b = src_b_q;
    assign bus.op_dst   = dst_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_uop_sequencer.sv
// Self-checking bench for uop_sequencer: registered ROM model, datapath
// responder, and a program-level reference model that predicts the issued
// ops, total cycle count and err flag from the ROM contents.
module tb_uop_sequencer;
    import uop_sequencer_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uop_sequencer_if bus();
    uop_state_e      state;

    uop_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state)
    );

    // Registered ROM: data valid one clock after the address.
    logic [19:0] rom [64];
    always @(posedge clk) bus.uop_data <= rom[bus.uop_addr];

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [23:0] exp_q[$];   // {addr, opcode, src_a, src_b, dst}
    logic [23:0] obs_q[$];

    function automatic logic [19:0] mk(input logic [3:0] op, input logic [4:0] sa,
                                       input logic [4:0] sb, input logic [3:0] ds,
                                       input logic [1:0] ex);
        return {op, sa, sb, ds, ex};
    endfunction

    function automatic logic [19:0] rand_word();
        logic [3:0] op;
        op = 4'($urandom_range(0, 14));
        return {op, 5'($urandom), 5'($urandom), 4'($urandom), 2'($urandom)};
    endfunction

    // Reference model: walk the program by the architectural rules.
    task automatic model_program(input bit cond, input int d, output int cost, output bit err);
        logic [19:0] w;
        bit run;
        exp_q.delete();
        cost = 0;
        err  = 1'b1;
        for (int a = 0; a < 64; a++) begin
            w = rom[a];
            if (w[19:16] == OPCODE_RDY) begin
                cost += 2;
                err = 1'b0;
                break;
            end
            case (w[1:0])
                2'b00:   run = 1'b1;
                2'b01:   run = cond;
                2'b10:   run = !cond;
                default: run = 1'b0;
            endcase
            if (run) begin
                exp_q.push_back({6'(a), w[19:2]});
                cost += 3 + d;
            end else begin
                cost += 2;
            end
        end
    endtask

    task automatic load_ecdh();
        for (int i = 0; i < 64; i++) rom[i] = rand_word();
        rom[0] = mk(OPCODE_MOV, UOP_SRC_G_X, 5'd0, UOP_DST_RX, UOP_EXEC_ALWAYS);
        rom[1] = mk(OPCODE_MOV, UOP_SRC_G_Y, 5'd0, UOP_DST_RY, UOP_EXEC_ALWAYS);
        rom[2] = mk(OPCODE_MOV, UOP_SRC_ONE, 5'd0, UOP_DST_RZ, UOP_EXEC_ALWAYS);
        rom[3] = mk(OPCODE_RDY, 5'd0, 5'd0, 4'd0, UOP_EXEC_ALWAYS);
    endtask

    // ---------------- driver: run one program to completion ----------------
    task automatic run_program(input string name, input bit cond, input int d,
                               input bit stray, output int n_trig);
        int cost;
        bit exp_err;
        int cycles;
        int cnt;
        int unstable;
        logic [17:0] snap;
        logic [17:0] cur;
        logic [23:0] o;
        logic [23:0] e;
        cycles   = 0;
        cnt      = 0;
        unstable = 0;
        snap     = '0;
        model_program(cond, d, cost, exp_err);
        obs_q.delete();
        bus.cond_bit = cond;
        @(negedge clk);
        bus.ena     = 1'b1;
        bus.op_done = 1'b0;
        @(negedge clk);
        bus.ena = 1'b0;
        checks++;
        if (bus.rdy !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL %s start_flags: rdy=%b err=%b required rdy=0 err=0", name, bus.rdy, bus.err);
        end
        while (bus.rdy !== 1'b1 && cycles < 6000) begin
            cur = {bus.op_code, bus.op_src_a, bus.op_src_b, bus.op_dst};
            if (bus.op_trig === 1'b1) begin
                obs_q.push_back({bus.uop_addr, cur});
                snap        = cur;
                cnt         = d;
                bus.op_done = 1'b0;
            end else if (cnt > 0) begin
                if (cur !== snap) unstable++;
                cnt--;
                bus.op_done = (cnt == 0);
            end else begin
                bus.op_done = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            bus.ena = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            cycles++;
        end
        bus.ena     = 1'b0;
        bus.op_done = 1'b0;
        n_trig      = obs_q.size();

        checks++;
        if (cycles >= 6000) begin
            failures++;
            $display("FAIL %s timeout: rdy never rose within %0d cycles", name, cycles);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        checks++;
        if (cycles != cost) begin
            failures++;
            $display("FAIL %s cycles: got %0d required %0d", name, cycles, cost);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s trig_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s op: got addr=%0d fields=%h required addr=%0d fields=%h",
                         name, o[23:18], o[17:0], e[23:18], e[17:0]);
            end
        end
        checks++;
        if (unstable != 0) begin
            failures++;
            $display("FAIL %s op_stable: %0d wait cycles with changed op fields, required 0", name, unstable);
        end
        checks++;
        if (bus.err !== exp_err || bus.uop_addr !== 6'd0 || bus.op_trig !== 1'b0) begin
            failures++;
            $display("FAIL %s end_state: err=%b addr=%0d trig=%b required err=%b addr=0 trig=0",
                     name, bus.err, bus.uop_addr, bus.op_trig, exp_err);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy: got %b required 1", bus.rdy); end
        checks++;
        if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b required 0", bus.err); end
        checks++;
        if (bus.uop_addr !== 6'd0) begin failures++; $display("FAIL reset_addr: got %0d required 0", bus.uop_addr); end
        checks++;
        if (bus.op_trig !== 1'b0) begin failures++; $display("FAIL reset_trig: got %b required 0", bus.op_trig); end
        checks++;
        if ({bus.op_code, bus.op_src_a, bus.op_src_b, bus.op_dst} !== 18'd0) begin
            failures++;
            $display("FAIL reset_fields: got %h required 0", {bus.op_code, bus.op_src_a, bus.op_src_b, bus.op_dst});
        end
        checks++;
        if (state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d required %0d", state, ST_IDLE); end
    endtask

    task automatic test_ecdh_init();
        int n;
        load_ecdh();
        run_program("ecdh_init", 1'b0, 1, 1'b0, n);
        checks++;
        if (n != 3) begin failures++; $display("FAIL ecdh_trigs: got %0d required 3", n); end
    endtask

    task automatic test_cond_exec();
        int n;
        for (int i = 0; i < 64; i++) rom[i] = rand_word();
        for (int i = 0; i < 12; i++) begin
            rom[i] = rand_word();
            rom[i][1:0] = 2'(1 + (i % 3));   // SET, CLR, NEVER rotating
        end
        rom[12] = mk(OPCODE_RDY, 5'd7, 5'd9, 4'd2, UOP_EXEC_NEVER);
        run_program("cond_set", 1'b1, 1, 1'b0, n);
        checks++;
        if (n != 4) begin failures++; $display("FAIL cond_set_trigs: got %0d required 4", n); end
        run_program("cond_clr", 1'b0, 2, 1'b0, n);
        checks++;
        if (n != 4) begin failures++; $display("FAIL cond_clr_trigs: got %0d required 4", n); end
        for (int i = 0; i < 6; i++) rom[i] = mk(OPCODE_ADD, 5'd1, 5'd2, 4'd3, UOP_EXEC_NEVER);
        rom[6] = mk(OPCODE_RDY, 5'd0, 5'd0, 4'd0, UOP_EXEC_ALWAYS);
        run_program("never_only", 1'($urandom_range(0, 1)), 1, 1'b0, n);
        checks++;
        if (n != 0) begin failures++; $display("FAIL never_trigs: got %0d required 0", n); end
    endtask

    task automatic test_long_wait();
        int n;
        load_ecdh();
        run_program("long_wait", 1'b1, 50, 1'b1, n);
    endtask

    task automatic test_runaway();
        int n;
        for (int i = 0; i < 64; i++)
            rom[i] = mk(OPCODE_MOV, 5'($urandom), 5'($urandom), 4'($urandom), UOP_EXEC_ALWAYS);
        run_program("runaway", 1'b0, 1, 1'b0, n);
        checks++;
        if (n != 64) begin failures++; $display("FAIL runaway_trigs: got %0d required 64", n); end
        checks++;
        if (bus.rdy !== 1'b1 || bus.err !== 1'b1) begin
            failures++;
            $display("FAIL runaway_flags: rdy=%b err=%b required rdy=1 err=1", bus.rdy, bus.err);
        end
        load_ecdh();
        run_program("after_runaway", 1'b1, 1, 1'b0, n);
    endtask

    task automatic test_reset_mid(input uop_state_e target, input string name);
        int waited;
        int n;
        load_ecdh();
        bus.op_done = 1'b0;
        @(negedge clk);
        bus.ena = 1'b1;
        @(negedge clk);
        bus.ena = 1'b0;
        waited = 0;
        while (state !== target && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 100) begin
            failures++;
            $display("FAIL %s reach_state: state %0d never reached", name, target);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.rdy, bus.err, bus.uop_addr, bus.op_trig, bus.op_code, bus.op_src_a, bus.op_src_b, bus.op_dst}
            !== {1'b1, 1'b0, 6'd0, 1'b0, 18'd0} || state !== ST_IDLE) begin
            failures++;
            $display("FAIL %s outputs: rdy=%b err=%b addr=%0d trig=%b fields=%h state=%0d required reset values",
                     name, bus.rdy, bus.err, bus.uop_addr, bus.op_trig,
                     {bus.op_code, bus.op_src_a, bus.op_src_b, bus.op_dst}, state);
        end
        run_program({name, "_restart"}, 1'b0, 1, 1'b0, n);
    endtask

    task automatic test_random();
        int n;
        int len;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 64; i++) rom[i] = rand_word();
            len = $urandom_range(1, 40);
            rom[len] = mk(OPCODE_RDY, 5'($urandom), 5'($urandom), 4'($urandom), 2'($urandom));
            run_program("random", 1'($urandom_range(0, 1)), $urandom_range(1, 4), 1'b1, n);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst          = 1'b1;
        bus.ena      = 1'b0;
        bus.op_done  = 1'b0;
        bus.cond_bit = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 20'd0;
        test_reset();
        test_ecdh_init();
        test_cond_exec();
        test_long_wait();
        test_runaway();
        test_reset_mid(ST_WAIT, "rst_in_wait");
        test_reset_mid(ST_DECODE, "rst_in_decode");
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
